axis_frame_tx: RTL and testbench
================================

// Module: axis_frame_tx
// PURPOSE
//  AXI-Stream master transmitter: drains LEN words from a sync-read result buffer as one AXIS frame toward the S2MM DMA path.
//  Drives the S2MM FIFO input on the output side of the accelerator wrapper, replacing free-running valid/last registers.
//  Honours tready backpressure at full throughput and asserts tlast exactly on the final beat.
// PARAMETERS
//  DATA_W   64  tdata / buffer word width
//  ADDR_W   3   buffer address width; max frame depth DEPTH = 2**ADDR_W
//  RD_LAT   1   buffer read latency in cycles (only 1 supported; elaboration error otherwise)
// PORTS
//  aclk           in   1            single clock, all logic on rising edge
//  areset         in   1            asynchronous, active-high reset
//  start          in   1            one-cycle pulse: begin frame (ignored while busy)
//  len_words      in   ADDR_W+1     frame length in words, sampled on accepted start
//  busy           out  1            high from accepted start until last beat accepted
//  done           out  1            one-cycle pulse the cycle after the final handshake
//  rd_en          out  1            buffer read strobe
//  rd_addr        out  ADDR_W       buffer read address
//  rd_data        in   DATA_W       buffer data, valid RD_LAT cycles after rd_en
//  m_axis_tready  in   1            downstream ready
//  m_axis_tdata   out  DATA_W       stream data
//  m_axis_tvalid  out  1            stream valid
//  m_axis_tlast   out  1            high on final beat of frame
// BEHAVIOUR
//  Reset: busy=0, done=0, rd_en=0, rd_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0; skid empty; state IDLE.
//  States: IDLE -> STREAM on start&&!busy&&len!=0; STREAM -> IDLE when last beat handshakes (tvalid&&tready&&tlast).
//  len_words==0: start ignored, no done. len_words>DEPTH: clamped to DEPTH.
//  Read issue: rd_en=1 when issued<len and (skid occupancy + reads in flight) < 2; rd_addr=issued count; issued++.
//  First tvalid no earlier than 2 cycles after start (issue + read latency); sustains 1 beat/cycle while tready=1.
//  Skid: 2-entry buffer captures rd_data; head drives tdata/tlast; pop on tvalid&&tready.
//  AXIS rules: tvalid never depends on tready; once tvalid=1, tdata/tlast hold until handshake; no bubbles forced.
//  tlast=1 only when head entry is word index len-1 (tag stored alongside data in skid).
//  Sent counter increments per handshake; never exceeds len; addresses never wrap within a frame.
//  start while busy: ignored, len not resampled. start same cycle as final handshake: ignored (busy still 1).
//  done pulses one cycle after final handshake; busy falls in that same cycle.
//  areset mid-frame: all outputs to reset values immediately (async); partial frame abandoned, no tlast, no done.
// CONFIGURATION
//  AXIS_TX_CHECKSUM_EN defined: after the len data beats one extra beat carries XOR of all data words;
//   tlast moves to that checksum beat; done follows its handshake; frame is len+1 beats; no buffer read for it.
//  Undefined: frame is exactly len beats; no checksum logic synthesized.
// STRUCTURE
//  Package axis_tx_pkg: state typedef (IDLE, STREAM), default DATA_W/ADDR_W, checksum seed constant (0).
//  Sub-module axis_skid2: 2-entry data+last FIFO with count output, push/pop same cycle allowed.
//  Top holds FSM, issue/sent counters, in-flight tracker, optional checksum accumulator.
// TESTING
//  len=5, tready=1 constant, buffer=0x10..0x14 -> 5 consecutive beats 0x10..0x14, tlast on 0x14, done next cycle.
//  len=5, tready toggles 1,0,0,1,... -> same data order, tdata/tlast stable while tvalid&&!tready, no lost/duplicate beats.
//  len=1 -> single beat with tlast=1; len=0 -> no rd_en, no tvalid, busy stays 0.
//  len=9 (DEPTH=8) -> exactly 8 beats addresses 0..7, tlast on address 7.
//  start pulsed mid-frame, then areset asserted after 2nd beat -> second start ignored; tvalid=0 immediately, no done.
//  AXIS_TX_CHECKSUM_EN, len=3, data 0x1,0x2,0x4 -> beats 0x1,0x2,0x4,0x7; tlast only on 0x7.

Source files
------------

// File: rtl/axis_tx_pkg.sv
// Shared types and defaults for the AXI-Stream frame transmitter.
package axis_tx_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 3;

   localparam logic [63:0] CSUM_SEED = 64'h0;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry data+last FIFO feeding the stream head; push and pop may coincide.
module axis_skid2 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         push_last,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         head_last,
   output logic [1:0]   count
);

   logic [W-1:0] data0_reg, data1_reg;
   logic         last0_reg, last1_reg;
   logic [1:0]   count_reg;

   // Entry 0 is always the head, so the stream outputs come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data0_reg <= '0;
         data1_reg <= '0;
         last0_reg <= 1'b0;
         last1_reg <= 1'b0;
         count_reg <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_reg == 2'd0) begin
                  data0_reg <= push_data;
                  last0_reg <= push_last;
               end else begin
                  data1_reg <= push_data;
                  last1_reg <= push_last;
               end
               count_reg <= count_reg + 2'd1;
            end
            2'b01: begin
               data0_reg <= data1_reg;
               last0_reg <= last1_reg;
               count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
               if (count_reg == 2'd1) begin
                  data0_reg <= push_data;
                  last0_reg <= push_last;
               end else begin
                  data0_reg <= data1_reg;
                  last0_reg <= last1_reg;
                  data1_reg <= push_data;
                  last1_reg <= push_last;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_data = data0_reg;
   assign head_last = last0_reg;
   assign count     = count_reg;

endmodule

// File: rtl/axis_frame_tx.sv
// Streams len_words buffer words out as one AXIS frame with tlast on the final beat.
// Optional AXIS_TX_CHECKSUM_EN appends an XOR checksum beat that carries tlast instead.
module axis_frame_tx
   import axis_tx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = 1
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              start,
   input  logic [ADDR_W:0]   len_words,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast
);

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_W);

   if (RD_LAT != 1) begin : g_rd_lat_check
      $error("axis_frame_tx: only RD_LAT=1 is supported");
   end

   state_t            state_reg;
   logic [CW-1:0]     len_reg;
   logic [CW-1:0]     issued_reg;
   logic              pending_reg;
   logic              pend_last_reg;
   logic              busy_reg;
   logic              done_reg;

   logic [DATA_W-1:0] skid_data;
   logic              skid_last;
   logic [1:0]        skid_count;
   logic              skid_valid;
   logic              data_pop;
   logic              final_hs;
   logic              start_ok;
   logic              issue;
   logic [2:0]        occ;
   logic [CW-1:0]     len_clamped;

   assign skid_valid  = (skid_count != 2'd0);
   assign start_ok    = (state_reg == IDLE) && start && (len_words != '0);
   assign len_clamped = (len_words > DEPTH_C) ? DEPTH_C : len_words;

   // Credit the pop happening this cycle so a steady 1 beat/cycle fits in two entries.
   assign occ   = {1'b0, skid_count} + {2'b00, pending_reg} - {2'b00, data_pop};
   assign issue = (state_reg == STREAM) && (issued_reg < len_reg) && (occ < 3'd2);

   assign rd_en   = issue;
   assign rd_addr = issued_reg[ADDR_W-1:0];
   assign busy    = busy_reg;
   assign done    = done_reg;

   axis_skid2 #(.W(DATA_W)) u_skid (
      .clk       (aclk),
      .rst       (areset),
      .push      (pending_reg),
      .push_data (rd_data),
      .push_last (pend_last_reg),
      .pop       (data_pop),
      .head_data (skid_data),
      .head_last (skid_last),
      .count     (skid_count)
   );

`ifdef AXIS_TX_CHECKSUM_EN
   logic              csum_valid_reg;
   logic [DATA_W-1:0] csum_reg;

   assign data_pop      = skid_valid && m_axis_tready;
   assign final_hs      = csum_valid_reg && m_axis_tready;
   assign m_axis_tvalid = skid_valid || csum_valid_reg;
   assign m_axis_tdata  = csum_valid_reg ? csum_reg : skid_data;
   assign m_axis_tlast  = csum_valid_reg;

   // The checksum beat only follows the last data word, so the skid is empty by then.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         csum_valid_reg <= 1'b0;
         csum_reg       <= DATA_W'(CSUM_SEED);
      end else begin
         if (start_ok) begin
            csum_reg <= DATA_W'(CSUM_SEED);
         end else if (data_pop) begin
            csum_reg <= csum_reg ^ skid_data;
            if (skid_last) begin
               csum_valid_reg <= 1'b1;
            end
         end
         if (final_hs) begin
            csum_valid_reg <= 1'b0;
         end
      end
   end
`else
   assign data_pop      = skid_valid && m_axis_tready;
   assign final_hs      = data_pop && skid_last;
   assign m_axis_tvalid = skid_valid;
   assign m_axis_tdata  = skid_data;
   assign m_axis_tlast  = skid_valid && skid_last;
`endif

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         issued_reg    <= '0;
         pending_reg   <= 1'b0;
         pend_last_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg    <= 1'b0;
         pending_reg <= issue;
         if (issue) begin
            issued_reg    <= issued_reg + 1'b1;
            pend_last_reg <= (issued_reg == len_reg - 1'b1);
         end
         case (state_reg)
            IDLE: begin
               if (start_ok) begin
                  state_reg  <= STREAM;
                  busy_reg   <= 1'b1;
                  len_reg    <= len_clamped;
                  issued_reg <= '0;
               end
            end
            STREAM: begin
               if (final_hs) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed self-checking bench for axis_frame_tx with a one-cycle sync-read buffer model.
module tb_axis_frame_tx;

   localparam int DW = 64;
   localparam int AW = 3;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   len_words = '0;
   logic          busy, done, rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic          m_axis_tready = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid, m_axis_tlast;

   logic [DW-1:0] mem [8];

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] beat_data [16];
   logic          beat_last [16];
   logic [AW-1:0] addr_log  [16];
   int            n_beats, n_rd, first_cyc, last_cyc, done_cyc, stab_err;
   logic          done_seen, busy_at_done;

   axis_frame_tx #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .start         (start),
      .len_words     (len_words),
      .busy          (busy),
      .done          (done),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic load_mem(input logic [DW-1:0] base);
      for (int i = 0; i < 8; i++) mem[i] = base + DW'(i);
   endtask

   task automatic start_frame(input int len);
      @(negedge aclk);
      start = 1'b1;
      len_words = len[AW:0];
      @(posedge aclk);
      #1;
      start = 1'b0;
   endtask

   // Records beats and read addresses until done or the cycle budget runs out.
   task automatic collect(input int budget, input int mode);
      logic          prev_hold;
      logic [DW-1:0] prev_data;
      logic          prev_last;
      n_beats = 0; n_rd = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
      stab_err = 0; done_seen = 1'b0; busy_at_done = 1'b1;
      prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge aclk);
         if (done) begin
            done_seen = 1'b1;
            done_cyc = c;
            busy_at_done = busy;
            break;
         end
         if (prev_hold && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
            stab_err++;
         m_axis_tready = (mode == 0) || (c % 4 == 0) || (c % 4 == 3);
         #1;
         if (rd_en && n_rd < 16) begin
            addr_log[n_rd] = rd_addr;
            n_rd++;
         end
         if (m_axis_tvalid && m_axis_tready && n_beats < 16) begin
            beat_data[n_beats] = m_axis_tdata;
            beat_last[n_beats] = m_axis_tlast;
            $display("beat %0d data=%h last=%0b cycle=%0d", n_beats, m_axis_tdata, m_axis_tlast, c);
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
            n_beats++;
         end
         prev_hold = m_axis_tvalid && !m_axis_tready;
         prev_data = m_axis_tdata;
         prev_last = m_axis_tlast;
      end
   endtask

   task automatic test_reset;
      areset = 1'b1;
      m_axis_tready = 1'b0;
      @(negedge aclk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
      checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); end
      checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %0b expected 0", m_axis_tlast); end
      checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
      areset = 1'b0;
      @(negedge aclk);
      $display("reset done");
   endtask

   task automatic test_basic;
      load_mem(64'h10);
      m_axis_tready = 1'b1;
      start_frame(5);
      collect(40, 0);
      checks++; if (n_beats !== 5) begin errors++; $display("FAIL basic_beats: got %0d expected 5", n_beats); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (beat_data[i] !== 64'h10 + DW'(i)) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, beat_data[i], 64'h10 + DW'(i)); end
         checks++; if (beat_last[i] !== (i == 4)) begin errors++; $display("FAIL basic_last[%0d]: got %0b expected %0b", i, beat_last[i], (i == 4)); end
      end
      checks++; if (!done_seen) begin errors++; $display("FAIL basic_done: done not seen within budget"); end
      checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b expected 0", busy_at_done); end
      checks++; if (done_cyc !== last_cyc + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_cyc + 1); end
      checks++; if (last_cyc - first_cyc !== 4) begin errors++; $display("FAIL basic_throughput: got span %0d expected 4", last_cyc - first_cyc); end
      checks++; if (first_cyc < 1) begin errors++; $display("FAIL basic_first_latency: got cycle %0d expected >=1", first_cyc); end
      checks++; if (n_rd !== 5) begin errors++; $display("FAIL basic_reads: got %0d expected 5", n_rd); end
      @(negedge aclk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b expected 0", done); end
   endtask

   task automatic test_backpressure;
      load_mem(64'h10);
      start_frame(5);
      collect(60, 1);
      checks++; if (n_beats !== 5) begin errors++; $display("FAIL bp_beats: got %0d expected 5", n_beats); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (beat_data[i] !== 64'h10 + DW'(i) || beat_last[i] !== (i == 4)) begin
            errors++; $display("FAIL bp_beat[%0d]: got %h/%0b expected %h/%0b", i, beat_data[i], beat_last[i], 64'h10 + DW'(i), (i == 4));
         end
      end
      checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d hold violations expected 0", stab_err); end
      checks++; if (!done_seen) begin errors++; $display("FAIL bp_done: done not seen within budget"); end
   endtask

   task automatic test_len1;
      load_mem(64'h40);
      m_axis_tready = 1'b1;
      start_frame(1);
      collect(20, 0);
      checks++; if (n_beats !== 1) begin errors++; $display("FAIL len1_beats: got %0d expected 1", n_beats); end
      checks++; if (beat_data[0] !== 64'h40 || beat_last[0] !== 1'b1) begin
         errors++; $display("FAIL len1_beat: got %h/%0b expected 40/1", beat_data[0], beat_last[0]);
      end
      checks++; if (!done_seen) begin errors++; $display("FAIL len1_done: done not seen within budget"); end
   endtask

   task automatic test_len0;
      int activity;
      activity = 0;
      m_axis_tready = 1'b1;
      start_frame(0);
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         if (rd_en || m_axis_tvalid || busy || done) activity++;
      end
      $display("len0 activity=%0d", activity);
      checks++; if (activity !== 0) begin errors++; $display("FAIL len0_idle: got %0d active cycles expected 0", activity); end
   endtask

   task automatic test_clamp;
      load_mem(64'h20);
      m_axis_tready = 1'b1;
      start_frame(9);
      collect(40, 0);
      checks++; if (n_beats !== 8) begin errors++; $display("FAIL clamp_beats: got %0d expected 8", n_beats); end
      checks++; if (n_rd !== 8) begin errors++; $display("FAIL clamp_reads: got %0d expected 8", n_rd); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (addr_log[i] !== AW'(i) || beat_data[i] !== 64'h20 + DW'(i)) begin
            errors++; $display("FAIL clamp_beat[%0d]: got addr %0d data %h expected addr %0d data %h", i, addr_log[i], beat_data[i], i, 64'h20 + DW'(i));
         end
      end
      checks++; if (beat_last[7] !== 1'b1 || beat_last[6] !== 1'b0) begin
         errors++; $display("FAIL clamp_last: got %0b,%0b expected 0,1", beat_last[6], beat_last[7]);
      end
      checks++; if (!done_seen) begin errors++; $display("FAIL clamp_done: done not seen within budget"); end
   endtask

   task automatic test_abort;
      int nb;
      int activity;
      nb = 0;
      load_mem(64'h50);
      m_axis_tready = 1'b1;
      start_frame(5);
      for (int c = 0; c < 20; c++) begin
         @(negedge aclk);
         start = (c == 0);
         if (c == 0) len_words = 4'd2;
         #1;
         if (m_axis_tvalid && m_axis_tready) begin
            beat_data[nb] = m_axis_tdata;
            beat_last[nb] = m_axis_tlast;
            $display("abort beat %0d data=%h last=%0b", nb, m_axis_tdata, m_axis_tlast);
            nb++;
            if (nb == 2) break;
         end
      end
      start = 1'b0;
      checks++; if (nb !== 2) begin errors++; $display("FAIL abort_beats: got %0d expected 2", nb); end
      checks++; if (beat_data[1] !== 64'h51 || beat_last[1] !== 1'b0) begin
         errors++; $display("FAIL abort_second_beat: got %h/%0b expected 51/0", beat_data[1], beat_last[1]);
      end
      @(posedge aclk);
      #1;
      areset = 1'b1;
      #1;
      checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
         errors++; $display("FAIL abort_tvalid: got tvalid %0b tlast %0b expected 0 0", m_axis_tvalid, m_axis_tlast);
      end
      checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin
         errors++; $display("FAIL abort_busy: got busy %0b rd_en %0b expected 0 0", busy, rd_en);
      end
      @(negedge aclk);
      areset = 1'b0;
      activity = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge aclk);
         if (done || m_axis_tvalid || busy) activity++;
      end
      checks++; if (activity !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", activity); end
   endtask

   task automatic test_back_to_back;
      int nb;
      int activity;
      logic hit;
      nb = 0; hit = 1'b0;
      load_mem(64'h30);
      m_axis_tready = 1'b1;
      start_frame(2);
      for (int c = 0; c < 20; c++) begin
         @(negedge aclk);
         #1;
         if (m_axis_tvalid && m_axis_tready) begin
            $display("b2b beat %0d data=%h last=%0b", nb, m_axis_tdata, m_axis_tlast);
            nb++;
            if (m_axis_tlast) begin
               start = 1'b1;
               len_words = 4'd3;
               hit = 1'b1;
               break;
            end
         end
      end
      checks++; if (!hit || nb !== 2) begin errors++; $display("FAIL b2b_frame: got %0d beats (last seen %0b) expected 2 (1)", nb, hit); end
      @(negedge aclk);
      start = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_done: got done %0b busy %0b expected 1 0", done, busy);
      end
      activity = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge aclk);
         if (m_axis_tvalid || busy || rd_en || done) activity++;
      end
      checks++; if (activity !== 0) begin errors++; $display("FAIL b2b_ignored_start: got %0d active cycles expected 0", activity); end
   endtask

   task automatic test_checksum;
      mem[0] = 64'h1; mem[1] = 64'h2; mem[2] = 64'h4;
      m_axis_tready = 1'b1;
      start_frame(3);
      collect(30, 0);
      checks++; if (n_beats !== 4) begin errors++; $display("FAIL csum_beats: got %0d expected 4", n_beats); end
      checks++; if (beat_data[0] !== 64'h1 || beat_data[1] !== 64'h2 || beat_data[2] !== 64'h4 || beat_data[3] !== 64'h7) begin
         errors++; $display("FAIL csum_data: got %h %h %h %h expected 1 2 4 7", beat_data[0], beat_data[1], beat_data[2], beat_data[3]);
      end
      checks++; if (beat_last[0] || beat_last[1] || beat_last[2] || !beat_last[3]) begin
         errors++; $display("FAIL csum_last: got %0b%0b%0b%0b expected 0001", beat_last[0], beat_last[1], beat_last[2], beat_last[3]);
      end
      checks++; if (!done_seen) begin errors++; $display("FAIL csum_done: done not seen within budget"); end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      test_reset;
`ifdef AXIS_TX_CHECKSUM_EN
      test_checksum;
`else
      test_basic;
      test_backpressure;
      test_len1;
      test_len0;
      test_clamp;
      test_abort;
      test_back_to_back;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
